// File: rtl/block_text_emitter.sv
// rtl/block_text_emitter.sv - serializes BEGIN/END/SPACE/PERIOD words as ASCII and tracks nesting depth
// Optional feature macro: MIXED_CASE_EN (alternates letter case across emitted letters).
module block_text_emitter #(
    parameter int         DEPTH_W   = 8,
    parameter logic [7:0] IDLE_CHAR = 8'h20
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic [1:0]         cmd,
    output logic               cmd_ready,
    output logic [7:0]         out,
    output logic               out_valid,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               error
);
    localparam logic [1:0] CMD_BEGIN  = 2'd0;
    localparam logic [1:0] CMD_END    = 2'd1;
    localparam logic [1:0] CMD_SPACE  = 2'd2;
    localparam logic [1:0] CMD_PERIOD = 2'd3;

    typedef enum logic {IDLE, EMIT} state_t;

    state_t             state_q, state_d;
    logic [1:0]         word_q, word_d;
    logic [2:0]         idx_q, idx_d;
    logic [7:0]         out_q, out_d;
    logic               out_valid_q, out_valid_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               error_q, error_d;
    logic               balanced_q, balanced_d;

    logic [2:0] last_idx;
    logic       last_char;
    logic       accept;
    logic [7:0] char_raw;
    logic [7:0] char_emit;

    // Index of the final character of the word in flight.
    always_comb begin
        last_idx = 3'd0;
        case (word_q)
            CMD_BEGIN: last_idx = 3'd5;
            CMD_END:   last_idx = 3'd3;
            default:   last_idx = 3'd0;
        endcase
    end

    always_comb begin
        char_raw = 8'h20;
        case (word_q)
            CMD_BEGIN: begin
                case (idx_q)
                    3'd0:    char_raw = "b";
                    3'd1:    char_raw = "e";
                    3'd2:    char_raw = "g";
                    3'd3:    char_raw = "i";
                    3'd4:    char_raw = "n";
                    default: char_raw = 8'h20;
                endcase
            end
            CMD_END: begin
                case (idx_q)
                    3'd0:    char_raw = "e";
                    3'd1:    char_raw = "n";
                    3'd2:    char_raw = "d";
                    default: char_raw = 8'h20;
                endcase
            end
            CMD_PERIOD: char_raw = 8'h2E;
            default:    char_raw = 8'h20;
        endcase
    end

`ifdef MIXED_CASE_EN
    logic toggle_q, toggle_d;
    logic is_letter;

    // Toggle advances only on letters so case alternation runs across word boundaries.
    always_comb begin
        is_letter = (char_raw != 8'h20) && (char_raw != 8'h2E);
        char_emit = (is_letter && toggle_q) ? (char_raw - 8'h20) : char_raw;
        toggle_d  = toggle_q ^ ((state_q == EMIT) && is_letter);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            toggle_q <= 1'b0;
        end else begin
            toggle_q <= toggle_d;
        end
    end
`else
    assign char_emit = char_raw;
`endif

    assign last_char = (state_q == EMIT) && (idx_q == last_idx);
    assign cmd_ready = (state_q == IDLE) || last_char;
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        out_d       = IDLE_CHAR;
        out_valid_d = 1'b0;
        depth_d     = depth_q;
        error_d     = error_q;

        if (state_q == EMIT) begin
            out_d       = char_emit;
            out_valid_d = 1'b1;
            idx_d       = idx_q + 3'd1;
            if (last_char) begin
                state_d = IDLE;
                idx_d   = 3'd0;
                // Depth moves with the trailing space, saturating at both ends.
                case (word_q)
                    CMD_BEGIN: begin
                        if (&depth_q) error_d = 1'b1;
                        else          depth_d = depth_q + DEPTH_W'(1);
                    end
                    CMD_END: begin
                        if (depth_q == '0) error_d = 1'b1;
                        else               depth_d = depth_q - DEPTH_W'(1);
                    end
                    default: ;
                endcase
            end
        end

        if (accept) begin
            state_d = EMIT;
            word_d  = cmd;
            idx_d   = 3'd0;
        end

        balanced_d = (depth_d == '0) && !error_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            word_q      <= CMD_BEGIN;
            idx_q       <= 3'd0;
            out_q       <= IDLE_CHAR;
            out_valid_q <= 1'b0;
            depth_q     <= '0;
            error_q     <= 1'b0;
            balanced_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            depth_q     <= depth_d;
            error_q     <= error_d;
            balanced_q  <= balanced_d;
        end
    end

    assign out       = out_q;
    assign out_valid = out_valid_q;
    assign depth     = depth_q;
    assign error     = error_q;
    assign balanced  = balanced_q;
endmodule

// File: tb/tb_block_text_emitter.sv
// tb/tb_block_text_emitter.sv - self-checking bench for block_text_emitter
module tb_block_text_emitter;
`ifdef MIXED_CASE_EN
    localparam bit MIXED = 1'b1;
`else
    localparam bit MIXED = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd = 2'd0;
    logic       cmd_ready;
    logic [7:0] out;
    logic       out_valid;
    logic [7:0] depth;
    logic       balanced, error;

    logic       cmd_valid2 = 1'b0;
    logic [1:0] cmd2 = 2'd0;
    logic       cmd_ready2;
    logic [7:0] out2;
    logic       out_valid2;
    logic [1:0] depth2;
    logic       balanced2, error2;

    block_text_emitter dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .cmd_ready(cmd_ready), .out(out), .out_valid(out_valid),
        .depth(depth), .balanced(balanced), .error(error)
    );

    block_text_emitter #(.DEPTH_W(2)) dut2 (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid2), .cmd(cmd2),
        .cmd_ready(cmd_ready2), .out(out2), .out_valid(out_valid2),
        .depth(depth2), .balanced(balanced2), .error(error2)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: expected character stream with the depth/error visible alongside each character.
    typedef struct {
        logic [7:0] ch;
        int         d;
        bit         e;
    } exp_t;

    exp_t exp_q[$];
    int   m_depth;
    bit   m_err;
    int   m_letters;

    function automatic string word_text(input logic [1:0] c);
        case (c)
            2'd0:    return "begin ";
            2'd1:    return "end ";
            2'd2:    return " ";
            default: return ".";
        endcase
    endfunction

    function automatic void m_reset();
        m_depth   = 0;
        m_err     = 1'b0;
        m_letters = 0;
        exp_q.delete();
    endfunction

    function automatic void m_push(input logic [1:0] c, input int maxd);
        string s;
        exp_t  x;
        s = word_text(c);
        for (int i = 0; i < s.len(); i++) begin
            x.ch = s[i];
            if (x.ch >= "a" && x.ch <= "z") begin
                if (MIXED && (m_letters % 2 == 1)) x.ch = x.ch - 8'd32;
                m_letters++;
            end
            if (i == s.len() - 1) begin
                if (c == 2'd0) begin
                    if (m_depth == maxd) m_err = 1'b1;
                    else                 m_depth++;
                end else if (c == 2'd1) begin
                    if (m_depth == 0) m_err = 1'b1;
                    else              m_depth--;
                end
            end
            x.d = m_depth;
            x.e = m_err;
            exp_q.push_back(x);
        end
    endfunction

    function automatic string fold(input string s);
        string r;
        int    n;
        r = s;
        n = 0;
        for (int i = 0; i < s.len(); i++) begin
            if (s[i] >= "a" && s[i] <= "z") begin
                if (MIXED && (n % 2 == 1)) r[i] = s[i] - 8'd32;
                n++;
            end
        end
        return r;
    endfunction

    task automatic do_reset();
        reset      = 1'b1;
        cmd_valid  = 1'b0;
        cmd_valid2 = 1'b0;
        tick();
        reset = 1'b0;
        m_reset();
    endtask

    task automatic check_out(input string tag);
        exp_t x;
        if (out_valid) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s_extra: got char %0h expected no character", tag, out);
            end else begin
                x = exp_q.pop_front();
                check({tag, "_char"}, out, x.ch);
                check({tag, "_depth"}, depth, x.d);
                check({tag, "_error"}, error, x.e);
                check({tag, "_balanced"}, balanced, (x.d == 0) && !x.e);
            end
        end else begin
            check({tag, "_idle_out"}, out, 8'h20);
        end
    endtask

    typedef struct {
        int         n;
        logic [5:0] cmds;
        string      txt;
        int         d;
        bit         e;
        logic [15:0] rmask;
    } vec_t;

    vec_t vecs[6];

    function automatic void set_vec(input int i, input int n, input logic [5:0] cmds, input string txt,
                                    input int d, input bit e, input logic [15:0] rmask);
        vecs[i].n     = n;
        vecs[i].cmds  = cmds;
        vecs[i].txt   = txt;
        vecs[i].d     = d;
        vecs[i].e     = e;
        vecs[i].rmask = rmask;
    endfunction

    task automatic run_vec(input int vi);
        vec_t        v;
        string       got, want;
        int          k, gaps, budget, pos;
        bit          started;
        logic        acc;
        logic [15:0] got_mask;
        v = vecs[vi];
        want = fold(v.txt);
        do_reset();
        k = 0;
        got = "";
        gaps = 0;
        budget = 0;
        started = 1'b0;
        got_mask = '0;
        cmd = v.cmds[1:0];
        cmd_valid = 1'b1;
        while (got.len() < want.len() && budget < 100) begin
            acc = cmd_valid && cmd_ready;
            tick();
            if (acc) begin
                k++;
                if (k < v.n) cmd = v.cmds[2*k +: 2];
                else         cmd_valid = 1'b0;
            end
            if (out_valid) begin
                pos = got.len();
                if (pos < want.len() - 1) got_mask[pos] = cmd_ready;
                got = $sformatf("%s%c", got, out);
                started = 1'b1;
            end else if (started) begin
                gaps++;
            end
            budget++;
        end
        cmd_valid = 1'b0;
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("FAIL vec%0d_text: got \"%s\" expected \"%s\"", vi, got, want);
        end
        check($sformatf("vec%0d_depth", vi), depth, v.d);
        check($sformatf("vec%0d_error", vi), error, v.e);
        check($sformatf("vec%0d_balanced", vi), balanced, (v.d == 0) && !v.e);
        check($sformatf("vec%0d_gaps", vi), gaps, 0);
        check($sformatf("vec%0d_ready_mask", vi), got_mask, v.rmask);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic acc;
        bit   found;
        int   sent, budget, acc_cnt, nch;

        set_vec(0, 1, 6'h00, "begin ",           1, 1'b0, 16'h0010);
        set_vec(1, 2, 6'h04, "begin end ",       0, 1'b0, 16'h0110);
        set_vec(2, 1, 6'h01, "end ",             0, 1'b1, 16'h0004);
        set_vec(3, 3, 6'h11, "end begin end ",   0, 1'b1, 16'h1104);
        set_vec(4, 3, 6'h0E, " .begin ",         1, 1'b0, 16'h0041);
        set_vec(5, 3, 6'h10, "begin begin end ", 1, 1'b0, 16'h4410);

        // Reset values.
        do_reset();
        check("rst_out", out, 8'h20);
        check("rst_out_valid", out_valid, 0);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_depth", depth, 0);
        check("rst_balanced", balanced, 1);
        check("rst_error", error, 0);

        // First-character latency.
        cmd = 2'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check("lat_not_yet", out_valid, 0);
        tick();
        check("lat_first_valid", out_valid, 1);
        check("lat_first_char", out, "b");

        for (int i = 0; i < 6; i++) run_vec(i);

        // Reset in the middle of a word, with a simultaneous command that must be ignored.
        do_reset();
        cmd = 2'd0;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            if (out_valid && out == "g") found = 1'b1;
            else tick();
        end
        check("midrst_g_seen", found, 1);
        reset = 1'b1;
        cmd = 2'd1;
        cmd_valid = 1'b1;
        tick();
        reset = 1'b0;
        cmd_valid = 1'b0;
        m_reset();
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out", out, 8'h20);
        check("midrst_depth", depth, 0);
        check("midrst_ready", cmd_ready, 1);
        check("midrst_error", error, 0);
        tick();
        tick();
        check("midrst_cmd_ignored", out_valid, 0);
        cmd = 2'd2;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        tick();
        check("midrst_space_valid", out_valid, 1);
        check("midrst_space_char", out, 8'h20);
        check("midrst_space_depth", depth, 0);
        check("midrst_space_balanced", balanced, 1);

        // Saturation on a 2-bit depth counter.
        do_reset();
        cmd2 = 2'd0;
        cmd_valid2 = 1'b1;
        acc_cnt = 0;
        nch = 0;
        for (int cyc = 0; cyc < 60 && nch < 24; cyc++) begin
            acc = cmd_valid2 && cmd_ready2;
            tick();
            if (acc) begin
                acc_cnt++;
                if (acc_cnt == 4) cmd_valid2 = 1'b0;
            end
            if (out_valid2) begin
                nch++;
                if (nch == 18) begin
                    check("sat_third_depth", depth2, 3);
                    check("sat_third_error", error2, 0);
                end
                if (nch == 24) begin
                    check("sat_fourth_depth", depth2, 3);
                    check("sat_fourth_error", error2, 1);
                    check("sat_fourth_balanced", balanced2, 0);
                end
            end
        end
        cmd_valid2 = 1'b0;
        check("sat_char_count", nch, 24);

        // Randomized command stream against the reference model.
        for (int run = 0; run < 3; run++) begin
            do_reset();
            sent = 0;
            budget = 0;
            while ((sent < 120 || exp_q.size() > 0) && budget < 5000) begin
                if (!cmd_valid && sent < 120 && $urandom_range(0, 3) != 0) begin
                    cmd_valid = 1'b1;
                    cmd = 2'($urandom_range(0, 3));
                end
                acc = cmd_valid && cmd_ready;
                tick();
                if (acc) begin
                    m_push(cmd, 255);
                    sent++;
                    cmd_valid = 1'b0;
                end
                check_out("rand");
                budget++;
            end
            cmd_valid = 1'b0;
            check("rand_drained", exp_q.size(), 0);
            check("rand_sent", sent, 120);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
